// File: rtl/adder_seq_pkg.sv
// Shared constants and state encoding for the multi-byte add sequencer.
package adder_seq_pkg;

  // Width of one byte lane. It is tied to the downstream adder, so it is not a parameter.
  localparam int BYTE_W     = 8;
  localparam int NBYTES_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_CAPT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/adder_seq_if.sv
// Operand and result handshakes between a client and the add sequencer.
interface adder_seq_if
  import adder_seq_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF
);

  logic                       in_valid;
  logic                       in_ready;
  logic [NBYTES*BYTE_W-1:0]   in_a;
  logic [NBYTES*BYTE_W-1:0]   in_b;
  logic                       in_cin;
  logic                       out_valid;
  logic                       out_ready;
  logic [NBYTES*BYTE_W:0]     out_sum;
  logic                       out_zero;

  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_zero
  );

endinterface

// File: rtl/adder_seq.sv
// Multi-byte add sequencer: feeds an external 8-bit registered adder one byte
// pair at a time (LSB first), chains its carry and assembles the wide sum.
//
// state | meaning
// IDLE  | ready for a new operand pair; adder output ignored
// WAIT  | adder is registering the current byte pair
// CAPT  | sm_r holds the current byte's sum; store it and advance or finish
// DONE  | result presented, held until out_ready
module adder_seq
  import adder_seq_pkg::*;
#(
  parameter int NBYTES = NBYTES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  adder_seq_if.slave        bus,
  output logic [BYTE_W-1:0] x,
  output logic [BYTE_W-1:0] y,
  output logic              cin,
  input  logic [BYTE_W:0]   sm_r
);

  localparam int W     = NBYTES * BYTE_W;
  localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_WAIT = ST_WAIT;
  localparam logic [1:0] S_CAPT = ST_CAPT;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     a_sh;
  logic [W-1:0]     b_sh;
  logic [W:0]       sum_r;
  logic             zero_acc;
  logic             out_valid_r;
  logic             out_zero_r;

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = sum_r;
  assign bus.out_zero  = out_zero_r;

  // Sequencing FSM, operand shift registers and result assembly.
  // zero_acc tracks whether every adder result seen so far (carry included) was zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      a_sh        <= '0;
      b_sh        <= '0;
      x           <= '0;
      y           <= '0;
      cin         <= 1'b0;
      sum_r       <= '0;
      zero_acc    <= 1'b0;
      out_valid_r <= 1'b0;
      out_zero_r  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            x        <= bus.in_a[BYTE_W-1:0];
            y        <= bus.in_b[BYTE_W-1:0];
            cin      <= bus.in_cin;
            a_sh     <= bus.in_a >> BYTE_W;
            b_sh     <= bus.in_b >> BYTE_W;
            idx      <= '0;
            zero_acc <= 1'b1;
            state    <= S_WAIT;
          end
        end
        S_WAIT: begin
          state <= S_CAPT;
        end
        S_CAPT: begin
          sum_r[idx*BYTE_W +: BYTE_W] <= sm_r[BYTE_W-1:0];
          if (idx != IDX_LAST) begin
            idx      <= idx + IDX_W'(1);
            x        <= a_sh[BYTE_W-1:0];
            y        <= b_sh[BYTE_W-1:0];
            a_sh     <= a_sh >> BYTE_W;
            b_sh     <= b_sh >> BYTE_W;
            cin      <= sm_r[BYTE_W];
            zero_acc <= zero_acc & (sm_r == '0);
            state    <= S_WAIT;
          end else begin
            sum_r[W]    <= sm_r[BYTE_W];
            out_zero_r  <= zero_acc & (sm_r == '0);
            out_valid_r <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_seq.sv
// Bench for adder_seq with a behavioural 8-bit registered adder in the loop.
module tb_adder_seq;

  localparam int NB = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst_n;
  logic [7:0] x;
  logic [7:0] y;
  logic       cin;
  logic [8:0] sm_r;

  int checks   = 0;
  int failures = 0;

  logic [7:0] tx [NB];
  logic [7:0] ty [NB];
  logic       tc [NB];

  adder_seq_if #(.NBYTES(NB)) bus ();

  adder_seq #(.NBYTES(NB)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .x    (x),
    .y    (y),
    .cin  (cin),
    .sm_r (sm_r)
  );

  always #5 clk = ~clk;

  assign rst_n = ~rst;

  // Stand-in for the existing registered adder.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) sm_r <= 9'd0;
    else        sm_r <= {1'b0, x} + {1'b0, y} + {8'd0, cin};
  end

  function automatic logic [32:0] ref_sum(input logic [31:0] a, input logic [31:0] b,
                                          input logic c);
    return {1'b0, a} + {1'b0, b} + {32'd0, c};
  endfunction

  // Carry entering byte k: carry out of the sum of the low k bytes.
  function automatic logic ref_carry_in(input logic [31:0] a, input logic [31:0] b,
                                        input logic c, input int k);
    logic [32:0] s;
    logic [31:0] m;
    if (k == 0) return c;
    m = (32'h1 << (8 * k)) - 32'h1;
    s = {1'b0, a & m} + {1'b0, b & m} + {32'd0, c};
    return s[8 * k];
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic c,
                        input string tag);
    logic [32:0] exp;
    int          edges;
    exp = ref_sum(a, b, c);
    @(negedge clk);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = c;
    bus.in_valid = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s in_ready_before_accept got=%b exp=1", tag, bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_a     = $urandom;
    bus.in_b     = $urandom;
    bus.in_cin   = 1'($urandom_range(0, 1));
    tx[0] = x; ty[0] = y; tc[0] = cin;
    edges = 0;
    while (bus.out_valid !== 1'b1 && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (edges % 2 == 0 && edges / 2 < NB) begin
        tx[edges/2] = x; ty[edges/2] = y; tc[edges/2] = cin;
      end
    end
    checks++;
    if (edges != 2 * NB) begin
      failures++;
      $display("FAIL %s latency got=%0d exp=%0d", tag, edges, 2 * NB);
    end
    checks++;
    if (bus.out_sum !== exp) begin
      failures++;
      $display("FAIL %s out_sum got=%h exp=%h", tag, bus.out_sum, exp);
    end
    checks++;
    if (bus.out_zero !== (exp == 33'd0)) begin
      failures++;
      $display("FAIL %s out_zero got=%b exp=%b", tag, bus.out_zero, exp == 33'd0);
    end
    for (int k = 0; k < NB; k++) begin
      checks++;
      if (tx[k] !== a[8*k +: 8] || ty[k] !== b[8*k +: 8] || tc[k] !== ref_carry_in(a, b, c, k)) begin
        failures++;
        $display("FAIL %s byte%0d_xy_cin got=%h/%h/%b exp=%h/%h/%b", tag, k, tx[k], ty[k], tc[k],
                 a[8*k +: 8], b[8*k +: 8], ref_carry_in(a, b, c, k));
      end
    end
    if (bus.out_ready === 1'b1) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        failures++;
        $display("FAIL %s release got valid=%b ready=%b exp valid=0 ready=1", tag,
                 bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_cin = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid_zero got=%b/%b exp=0/0", bus.out_valid, bus.out_zero);
    end
    checks++;
    if (bus.out_sum !== 33'd0) begin
      failures++;
      $display("FAIL reset_out_sum got=%h exp=0", bus.out_sum);
    end
    checks++;
    if (x !== 8'd0 || y !== 8'd0 || cin !== 1'b0) begin
      failures++;
      $display("FAIL reset_xy_cin got=%h/%h/%b exp=00/00/0", x, y, cin);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
    end
  endtask

  task automatic test_directed();
    bus.out_ready = 1'b1;
    run_op(32'h11223344, 32'h22334455, 1'b1, "basic");
    run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, "ripple");
    run_op(32'h00000000, 32'h00000000, 1'b0, "zero");
    run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, "zero_carry");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, "max");
  endtask

  task automatic test_random();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      run_op($urandom, $urandom, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a1, b1, a2, b2;
    logic        c1, c2;
    logic [32:0] exp1;
    a1 = $urandom; b1 = $urandom; c1 = 1'($urandom_range(0, 1));
    a2 = $urandom; b2 = $urandom; c2 = 1'($urandom_range(0, 1));
    exp1 = ref_sum(a1, b1, c1);
    bus.out_ready = 1'b0;
    run_op(a1, b1, c1, "bp_first");
    @(negedge clk);
    bus.in_a = a2; bus.in_b = b2; bus.in_cin = c2; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_sum !== exp1 || bus.in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cyc%0d got valid=%b sum=%h ready=%b exp valid=1 sum=%h ready=0",
                 i, bus.out_valid, bus.out_sum, bus.in_ready, exp1);
      end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release got valid=%b ready=%b exp valid=0 ready=1",
               bus.out_valid, bus.in_ready);
    end
    run_op(a2, b2, c2, "bp_second");
  endtask

  task automatic test_mid_reset();
    bit seen_valid;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_a = $urandom; bus.in_b = $urandom; bus.in_cin = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || x !== 8'd0 || bus.out_sum !== 33'd0) begin
      failures++;
      $display("FAIL midrst_state got valid=%b ready=%b x=%h sum=%h exp 0/1/00/0",
               bus.out_valid, bus.in_ready, x, bus.out_sum);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid) begin
      failures++;
      $display("FAIL midrst_no_valid got=1 exp=0");
    end
    run_op(32'd1, 32'd2, 1'b0, "after_reset");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
